ddfs_seq: RTL and testbench
===========================

DDFS_SEQ -- requirements
Module: ddfs_seq

Interface
REQ-001 SHALL have parameter PW, default 30, phase/FCCW width matching the DDFS.
REQ-002 SHALL have parameter DEPTH, default 16, note FIFO entries (power of 2).
REQ-003 SHALL have parameter DW, default 16, duration/gap counter width.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cs, write, read  in  1 each  MMIO slot select and strobes.
REQ-007 addr  in  5  MMIO register address; only addr[1:0] decoded.
REQ-008 write_data  in  32  MMIO write data.
REQ-009 read_data  out  32  status word, combinational.
REQ-010 tick  in  1  sample strobe (DDFS data_valid), one cycle wide.
REQ-011 fccw_out  out  PW  carrier FCCW to DDFS.
REQ-012 env_out  out  16  envelope to DDFS env_ext, Q2.14.
REQ-013 gate  out  1  high while a note plays.
REQ-014 note_start  out  1  one-cycle pulse per note dequeued.

Function
REQ-015 Write addr 0 SHALL load fccw_stage <= write_data[PW-1:0].
REQ-016 Write addr 1 SHALL push {fccw_stage, write_data[DW-1:0]} into the note FIFO.
REQ-017 Push while full SHALL be dropped and SHALL set sticky ovf.
REQ-018 Write addr 2 (ctrl): bit0 run level; bit1 flush, self-clearing; bit2 ovf clear, self-clearing.
REQ-019 Write addr 3 SHALL load gap_reg <= write_data[DW-1:0].
REQ-020 read_data SHALL be {count in [31:16], 9'b0, state in [6:5], ovf [4], run [3], full [2], empty [1], busy [0]}; busy = state != IDLE.
REQ-021 FSM states: IDLE, LOAD, PLAY, GAP.
REQ-022 IDLE -> LOAD when run & !empty.
REQ-023 LOAD (one cycle): pop FIFO, fccw_out <= entry fccw, cnt <= max(dur,1), pulse note_start -> PLAY.
REQ-024 PLAY: decrement cnt on each tick; on the tick that reaches 0: GAP if gap_reg != 0 (cnt <= gap_reg), else LOAD if run & !empty, else IDLE.
REQ-025 GAP: decrement cnt on each tick; at 0 -> LOAD if run & !empty, else IDLE.
REQ-026 A note SHALL last exactly max(dur,1) ticks; dur = 0 SHALL be treated as 1.
REQ-027 gate = 1 and env_out = 16'h4000 only in PLAY; otherwise gate = 0 and env_out = 0.
REQ-028 fccw_out SHALL hold its last value through GAP and IDLE.
REQ-029 run = 0 in any state SHALL force IDLE on the next cycle, without popping; FIFO contents are kept.
REQ-030 Flush SHALL empty the FIFO; a note in progress SHALL finish normally.
REQ-031 Simultaneous push and pop SHALL both occur; count stays unchanged.
REQ-032 Push and flush in the same cycle: flush wins and the push is discarded.
REQ-033 A tick arriving in the LOAD cycle SHALL be ignored.

Reset
REQ-034 Reset SHALL set: state IDLE, FIFO empty, fccw_stage 0, fccw_out 0, gap_reg 0, run 0, ovf 0, cnt 0, gate 0, env_out 0, note_start 0.

Structure
REQ-035 Package ddfs_seq_pkg SHALL hold the state enum, register address constants, ctrl bit indices and ENV_ON = 16'h4000.
REQ-036 The note FIFO SHALL be a sub-module fifo_sync, with width PW+DW and depth DEPTH, providing full, empty and count outputs.

Verification
REQ-037 fccw 0x1000, dur 3, gap 0, run=1 -> note_start once, gate high for exactly 3 ticks, fccw_out = 0x1000, then IDLE and gate 0.
REQ-038 Two notes (dur 2, 2) with gap 2 -> gate pattern 2 ticks on, 2 off, 2 on, 2 off; fccw_out held through gaps.
REQ-039 Push DEPTH+1 entries with run = 0 -> full = 1, ovf = 1, count = DEPTH; ctrl bit2 -> ovf = 0.
REQ-040 run cleared mid-PLAY -> IDLE next cycle, gate 0, env_out 0, remaining count unchanged.
REQ-041 dur = 0 entry -> gate high for exactly 1 tick; flush during PLAY -> current note completes, then IDLE with empty = 1.

Source files
------------

// File: rtl/ddfs_seq_pkg.sv
// Shared definitions for the DDFS note sequencer: FSM states, MMIO
// register map, control-word bit positions and the envelope level.
package ddfs_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } seq_state_t;

    // MMIO register map (only the two low address bits are decoded)
    localparam logic [1:0] ADDR_FCCW = 2'd0;
    localparam logic [1:0] ADDR_NOTE = 2'd1;
    localparam logic [1:0] ADDR_CTRL = 2'd2;
    localparam logic [1:0] ADDR_GAP  = 2'd3;

    // Control word bit positions
    localparam int CTRL_RUN     = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_OVF_CLR = 2;

    // Envelope applied while a note is sounding: 1.0 in Q2.14
    localparam logic [15:0] ENV_ON = 16'h4000;

endpackage

// File: rtl/ddfs_seq_fifo_sync.sv
// Synchronous note FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguished without a separate occupancy counter.
// DEPTH must be a power of two, at least 2.
module fifo_sync #(
    parameter int WIDTH = 46,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Flush has priority over both push and pop in the same cycle;
    // a push into a full FIFO is dropped even if a pop also happens.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush simply rewinds both pointers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the pointers
        // define which entries are valid, and leaving it out keeps it
        // mappable onto RAM.
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ddfs_seq.sv
// Note sequencer for a DDFS: MMIO-loaded note queue, each entry an
// FCCW plus a duration in sample ticks, played back with an optional
// silent gap between notes.
module ddfs_seq
    import ddfs_seq_pkg::*;
#(
    parameter int PW    = 30,
    parameter int DEPTH = 16,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs,
    input  logic          write,
    input  logic          read,
    input  logic [4:0]    addr,
    input  logic [31:0]   write_data,
    output logic [31:0]   read_data,
    input  logic          tick,
    output logic [PW-1:0] fccw_out,
    output logic [15:0]   env_out,
    output logic          gate,
    output logic          note_start
);

    localparam int EW = PW + DW;
    localparam int CW = $clog2(DEPTH) + 1;

    seq_state_t    state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] fccw_q, fccw_d;

    logic [PW-1:0] fccw_stage;
    logic [DW-1:0] gap_reg;
    logic          run_q;
    logic          ovf_q;

    logic          wr_en;
    logic          sel_fccw, sel_note, sel_ctrl, sel_gap;
    logic          flush, ovf_clr;

    logic          fifo_pop;
    logic [EW-1:0] fifo_rd_data;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [PW-1:0] entry_fccw;
    logic [DW-1:0] entry_dur;

    logic          can_load;
    logic          cnt_last;

    // Reads have no side effects, so the strobe and upper address bits
    // carry no information for this block.
    logic          unused_inputs;
    assign unused_inputs = ^{read, addr[4:2], write_data};

    assign wr_en    = cs && write;
    assign sel_fccw = wr_en && (addr[1:0] == ADDR_FCCW);
    assign sel_note = wr_en && (addr[1:0] == ADDR_NOTE);
    assign sel_ctrl = wr_en && (addr[1:0] == ADDR_CTRL);
    assign sel_gap  = wr_en && (addr[1:0] == ADDR_GAP);
    assign flush    = sel_ctrl && write_data[CTRL_FLUSH];
    assign ovf_clr  = sel_ctrl && write_data[CTRL_OVF_CLR];

    // MMIO-writable configuration and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            fccw_stage <= '0;
            gap_reg    <= '0;
            run_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (sel_fccw) fccw_stage <= write_data[PW-1:0];
            if (sel_gap)  gap_reg    <= write_data[DW-1:0];
            if (sel_ctrl) run_q      <= write_data[CTRL_RUN];
            if (ovf_clr)
                ovf_q <= 1'b0;
            else if (sel_note && fifo_full)
                ovf_q <= 1'b1;
        end
    end

    fifo_sync #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (sel_note),
        .pop     (fifo_pop),
        .flush   (flush),
        .wr_data ({fccw_stage, write_data[DW-1:0]}),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign entry_fccw = fifo_rd_data[EW-1:DW];
    assign entry_dur  = fifo_rd_data[DW-1:0];

    assign can_load = run_q && !fifo_empty;
    // cnt never legitimately sits at 0 in PLAY/GAP; treating <=1 as the
    // final tick keeps the FSM from wrapping if it ever did.
    assign cnt_last = (cnt_q <= DW'(1));

    // FSM, countdown and carrier FCCW registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fccw_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fccw_q  <= fccw_d;
        end
    end

    // Next-state, countdown and per-state outputs.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a variable unassigned, which would infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        fccw_d     = fccw_q;
        fifo_pop   = 1'b0;
        note_start = 1'b0;
        gate       = 1'b0;
        env_out    = '0;

        case (state_q)
            ST_IDLE: begin
                if (can_load) state_d = ST_LOAD;
            end

            // One-cycle fetch; ticks here are ignored. A flush in the
            // previous cycle can leave nothing to fetch.
            ST_LOAD: begin
                if (!run_q || fifo_empty) begin
                    state_d = ST_IDLE;
                end else begin
                    fifo_pop   = 1'b1;
                    note_start = 1'b1;
                    fccw_d     = entry_fccw;
                    cnt_d      = (entry_dur == '0) ? DW'(1) : entry_dur;
                    state_d    = ST_PLAY;
                end
            end

            ST_PLAY: begin
                gate    = 1'b1;
                env_out = ENV_ON;
                if (!run_q) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (cnt_last) begin
                        if (gap_reg != '0) begin
                            cnt_d   = gap_reg;
                            state_d = ST_GAP;
                        end else begin
                            cnt_d   = '0;
                            state_d = can_load ? ST_LOAD : ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - DW'(1);
                    end
                end
            end

            ST_GAP: begin
                if (!run_q) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (cnt_last) begin
                        cnt_d   = '0;
                        state_d = can_load ? ST_LOAD : ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - DW'(1);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign fccw_out  = fccw_q;
    assign read_data = {16'(fifo_count), 9'b0, state_q, ovf_q, run_q,
                        fifo_full, fifo_empty, (state_q != ST_IDLE)};

endmodule

// File: tb/tb_ddfs_seq.sv
// Self-checking bench for ddfs_seq: scoreboard of expected notes fed by
// the stimulus, consumed by an independent monitor on note_start.
module tb_ddfs_seq;
    import ddfs_seq_pkg::*;

    localparam int PW    = 30;
    localparam int DEPTH = 16;
    localparam int DW    = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic          clk;
    logic          reset;
    logic          cs, write, read;
    logic [4:0]    addr;
    logic [31:0]   write_data;
    logic [31:0]   read_data;
    logic          tick;
    logic [PW-1:0] fccw_out;
    logic [15:0]   env_out;
    logic          gate;
    logic          note_start;

    ddfs_seq #(.PW(PW), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .write      (write),
        .read       (read),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .tick       (tick),
        .fccw_out   (fccw_out),
        .env_out    (env_out),
        .gate       (gate),
        .note_start (note_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] fccw;
        int            ticks;
        int            gap;
    } note_t;

    note_t exp_q[$];
    int    n_cmp    = 0;
    int    n_err    = 0;
    int    n_notes  = 0;
    int    n_expect = 0;
    int    tick_mode = 0;   // 0 none, 1 random, 2 every cycle
    logic  run_lvl  = 1'b0;
    logic [PW-1:0] pw_mask = '1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] dut_state();
        return read_data[6:5];
    endfunction

    function automatic logic gen_tick();
        if (tick_mode == 2) return 1'b1;
        if (tick_mode == 1) return ($urandom_range(2) == 0);
        return 1'b0;
    endfunction

    task automatic idle_cycle();
        cs    = 1'b0;
        write = 1'b0;
        tick  = gen_tick();
        @(posedge clk); #1;
    endtask

    task automatic mmio_write(input logic [1:0] a, input logic [31:0] d);
        cs         = 1'b1;
        write      = 1'b1;
        addr       = {3'($urandom_range(7)), a};
        write_data = d;
        tick       = gen_tick();
        @(posedge clk); #1;
        cs    = 1'b0;
        write = 1'b0;
    endtask

    task automatic set_ctrl(input logic run, input logic fl, input logic oc);
        logic [31:0] w;
        w = '0;
        w[CTRL_RUN]     = run;
        w[CTRL_FLUSH]   = fl;
        w[CTRL_OVF_CLR] = oc;
        run_lvl = run;
        mmio_write(ADDR_CTRL, w);
        if (fl) begin
            n_expect -= exp_q.size();
            exp_q.delete();
        end
    endtask

    // Queue a note; the model accepts it only if the queue has room.
    task automatic push_note(input logic [PW-1:0] f, input int dur,
                             input int ticks, input int gap);
        note_t e;
        mmio_write(ADDR_FCCW, 32'(f));
        mmio_write(ADDR_NOTE, 32'(dur));
        if (exp_q.size() < DEPTH) begin
            e.fccw  = f;
            e.ticks = ticks;
            e.gap   = gap;
            exp_q.push_back(e);
            n_expect++;
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (!(dut_state() == S_IDLE && read_data[1]) && k < 3000) begin
            idle_cycle();
            k++;
        end
        check(name, 32'(dut_state()), 32'(S_IDLE));
    endtask

    task automatic wait_play(input string name, input logic [PW-1:0] f);
        int k;
        k = 0;
        while (!(dut_state() == S_PLAY && fccw_out == f) && k < 3000) begin
            idle_cycle();
            k++;
        end
        check(name, 32'(dut_state()), 32'(S_PLAY));
    endtask

    // Monitor: on each note_start, pop the expected note and measure the
    // played length and following gap in ticks.
    initial begin : monitor
        note_t e;
        int    n, m, b;
        @(negedge clk);
        forever begin
            if (note_start === 1'b1) begin
                n_notes++;
                check("note_expected", 32'(exp_q.size() == 0), 32'd0);
                if (exp_q.size() != 0) e = exp_q.pop_front();
                @(negedge clk);
                check("play_fccw", 32'(fccw_out), 32'(e.fccw));
                check("play_gate", 32'(gate), 32'd1);
                check("play_env", 32'(env_out), 32'h4000);
                n = 0;
                b = 0;
                while (gate && b < 5000) begin
                    @(posedge clk);
                    if (tick) n++;
                    @(negedge clk);
                    b++;
                end
                check("note_ticks", 32'(n), 32'(e.ticks));
                m = 0;
                b = 0;
                while (dut_state() == S_GAP && b < 5000) begin
                    check("gap_gate", 32'(gate), 32'd0);
                    @(posedge clk);
                    if (tick) m++;
                    @(negedge clk);
                    b++;
                end
                check("gap_ticks", 32'(m), 32'(e.gap));
                check("fccw_held", 32'(fccw_out), 32'(e.fccw));
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin : stimulus
        logic [PW-1:0] f;
        int            d, g, np;
        reset      = 1'b1;
        cs         = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        addr       = '0;
        write_data = '0;
        tick       = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_status", read_data, 32'h0000_0002);
        check("rst_gate", 32'(gate), 32'd0);
        check("rst_env", 32'(env_out), 32'd0);
        check("rst_note_start", 32'(note_start), 32'd0);
        check("rst_fccw", 32'(fccw_out), 32'd0);

        // Single note, dur 3, no gap
        tick_mode = 1;
        mmio_write(ADDR_GAP, 32'd0);
        push_note(30'h1000, 3, 3, 0);
        set_ctrl(1'b1, 1'b0, 1'b0);
        wait_idle("single_done");
        check("single_status", read_data, 32'h0000_000A);
        check("single_gate", 32'(gate), 32'd0);
        check("single_fccw", 32'(fccw_out), 32'h1000);
        check("single_count", 32'(n_notes), 32'd1);

        // Two notes dur 2 with gap 2, ticks every cycle
        tick_mode = 2;
        mmio_write(ADDR_GAP, 32'd2);
        push_note(30'h0ABC, 2, 2, 2);
        push_note(30'h1DEF, 2, 2, 2);
        wait_idle("gap_done");
        check("gap_fccw_final", 32'(fccw_out), 32'h1DEF);

        // Overflow with run off
        tick_mode = 0;
        set_ctrl(1'b0, 1'b0, 1'b0);
        mmio_write(ADDR_GAP, 32'd0);
        for (int i = 0; i < DEPTH + 1; i++)
            push_note($urandom & pw_mask, $urandom_range(1, 4), 0, 0);
        check("full_status", read_data, (32'(DEPTH) << 16) | 32'h14);
        set_ctrl(1'b0, 1'b0, 1'b1);
        check("ovf_clr_status", read_data, (32'(DEPTH) << 16) | 32'h04);
        set_ctrl(1'b0, 1'b1, 1'b0);
        check("flush_status", read_data, 32'h0000_0002);

        // Run cleared mid-note
        push_note(30'h0555, 5, 2, 0);
        push_note(30'h0666, 4, 4, 0);
        set_ctrl(1'b1, 1'b0, 1'b0);
        wait_play("runclr_play", 30'h0555);
        tick_mode = 2;
        idle_cycle();
        idle_cycle();
        tick_mode = 0;
        check("runclr_count_before", 32'(read_data[31:16]), 32'd1);
        set_ctrl(1'b0, 1'b0, 1'b0);
        idle_cycle();
        check("runclr_state", 32'(dut_state()), 32'(S_IDLE));
        check("runclr_gate", 32'(gate), 32'd0);
        check("runclr_env", 32'(env_out), 32'd0);
        check("runclr_count_after", 32'(read_data[31:16]), 32'd1);

        // dur 0 plays one tick; flush during a note lets it finish
        push_note(30'h2222, 0, 1, 0);
        push_note(30'h3333, 6, 6, 0);
        push_note(30'h4444, 3, 3, 0);
        tick_mode = 1;
        set_ctrl(1'b1, 1'b0, 1'b0);
        wait_play("flush_play", 30'h3333);
        set_ctrl(1'b1, 1'b1, 1'b0);
        wait_idle("flush_done");
        check("flush_empty", 32'(read_data[1]), 32'd1);
        check("flush_fccw", 32'(fccw_out), 32'h3333);

        // Random batches, pushes overlapping playback
        for (int bt = 0; bt < 6; bt++) begin
            g = $urandom_range(3);
            mmio_write(ADDR_GAP, 32'(g));
            np = $urandom_range(1, 5);
            for (int i = 0; i < np; i++) begin
                repeat ($urandom_range(8)) idle_cycle();
                f = $urandom & pw_mask;
                d = $urandom_range(4);
                push_note(f, d, (d == 0) ? 1 : d, g);
            end
            wait_idle("rand_done");
        end

        repeat (4) idle_cycle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("notes_started", 32'(n_notes), 32'(n_expect));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
